// File: rtl/ysyx22041405_id_sched.sv
// ysyx22041405_id_sched: in-order issue scheduler with a per-register pending-write scoreboard.
module ysyx22041405_id_sched #(
   parameter int MAX_PEND = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   input  logic             rs1_use,
   input  logic             rs2_use,
   input  logic [4:0]       rd_addr,
   input  logic             rd_we,
   input  logic             fence,
   input  logic             ex_ready,
   output logic             issue_valid,
   input  logic             wb_valid,
   input  logic [4:0]       wb_addr,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2} state_e;
   state_e           state_q, state_d;
   logic [1:0]       pend_q [32];
   logic [1:0]       pend_d [32];
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             raw, waw, fence_blk, any_pend;
   // Entry 0 is never incremented or decremented, so it stays at zero.
   always_comb begin
      any_pend = 1'b0;
      for (int i = 0; i < 32; i++) any_pend = any_pend | (pend_q[i] != 2'd0);
      raw         = (rs1_use && pend_q[rs1_addr] != 2'd0) || (rs2_use && pend_q[rs2_addr] != 2'd0);
      waw         = rd_we && rd_addr != 5'd0 && pend_q[rd_addr] == 2'(MAX_PEND);
      fence_blk   = fence && any_pend;
      issue_valid = rst && id_valid && ex_ready && !flush && !raw && !waw && !fence_blk;
      id_ready    = issue_valid || (rst && flush);
      stall       = rst && id_valid && !flush && !issue_valid;
      state_d     = (flush || !stall) ? RUN : fence_blk ? DRAIN : STALL;
      stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      for (int i = 0; i < 32; i++)
         pend_d[i] = pend_q[i]
                   + 2'(issue_valid && rd_we && i != 0 && rd_addr == 5'(i))
                   - 2'(wb_valid && i != 0 && wb_addr == 5'(i) && pend_q[i] != 2'd0);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         for (int i = 0; i < 32; i++) pend_q[i] <= 2'd0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
      end
   end
   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_ysyx22041405_id_sched.sv
// tb_ysyx22041405_id_sched: directed and randomized checks against a scoreboard model.
module tb_ysyx22041405_id_sched;
   localparam int MP = 3, CW = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic id_valid = 0, rs1_use = 0, rs2_use = 0, rd_we = 0, fence = 0, ex_ready = 0, wb_valid = 0, flush = 0;
   logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0, wb_addr = 0;
   logic id_ready, issue_valid, stall;
   logic [1:0] state;
   logic [CW-1:0] stall_cnt;
   int tests = 0, fails = 0;
   int pend_m [32];
   int st_m = 0, cnt_m = 0;
   bit e_issue, e_stall, e_fblk;

   ysyx22041405_id_sched #(.MAX_PEND(MP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_use(rs1_use), .rs2_use(rs2_use),
      .rd_addr(rd_addr), .rd_we(rd_we), .fence(fence), .ex_ready(ex_ready),
      .issue_valid(issue_valid), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
      .stall(stall), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      foreach (pend_m[i]) pend_m[i] = 0;
      st_m = 0;
      cnt_m = 0;
   endtask

   task automatic idle();
      {id_valid, rs1_use, rs2_use, rd_we, fence, ex_ready, wb_valid, flush} = '0;
      {rs1_addr, rs2_addr, rd_addr, wb_addr} = '0;
   endtask

   task automatic predict();
      bit raw, waw, any;
      any = 0;
      foreach (pend_m[i]) if (pend_m[i] != 0) any = 1;
      raw = (rs1_use && pend_m[rs1_addr] != 0) || (rs2_use && pend_m[rs2_addr] != 0);
      waw = rd_we && rd_addr != 0 && pend_m[rd_addr] == MP;
      e_fblk  = fence && any;
      e_issue = id_valid && ex_ready && !flush && !raw && !waw && !e_fblk;
      e_stall = id_valid && !flush && !e_issue;
   endtask

   task automatic tick();
      bit dec;
      predict();
      dec = wb_valid && wb_addr != 0 && pend_m[wb_addr] > 0;
      @(posedge clk);
      if (dec) pend_m[wb_addr]--;
      if (e_issue && rd_we && rd_addr != 0) pend_m[rd_addr]++;
      st_m = (flush || !e_stall) ? 0 : e_fblk ? 2 : 1;
      if (e_stall && cnt_m < 2**CW - 1) cnt_m++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      id_valid = 1; ex_ready = 1; flush = 1;
      #1;
      tests++;
      if ({issue_valid, id_ready, stall} !== 3'b000 || state !== 2'd0 || stall_cnt !== '0) begin
         fails++;
         $display("FAIL reset_outputs: iv/rdy/stall=%b%b%b state=%0d cnt=%0d, want 000 0 0", issue_valid, id_ready, stall, state, stall_cnt);
      end
      @(negedge clk);
      rst = 1; idle(); model_reset();
   endtask

   task automatic test_raw();
      idle(); id_valid = 1; ex_ready = 1; rd_we = 1; rd_addr = 5;
      #1; tests++;
      if (issue_valid !== 1'b1) begin fails++; $display("FAIL raw_first_issue: issue_valid=%b want 1", issue_valid); end
      tick();
      rd_we = 0; rs1_addr = 5; rs1_use = 1;
      #1; tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall: stall=%b want 1", stall); end
      tick(); tests++;
      if (state !== 2'd1) begin fails++; $display("FAIL raw_state: state=%0d want 1", state); end
      wb_valid = 1; wb_addr = 5;
      #1; tests++;
      if (stall !== 1'b1 || issue_valid !== 1'b0) begin fails++; $display("FAIL raw_no_bypass: stall=%b issue=%b want 1 0", stall, issue_valid); end
      tick();
      wb_valid = 0;
      #1; tests++;
      if (issue_valid !== 1'b1 || id_ready !== 1'b1) begin fails++; $display("FAIL raw_release: issue=%b ready=%b want 1 1", issue_valid, id_ready); end
      tick(); tests++;
      if (state !== 2'd0) begin fails++; $display("FAIL raw_back_run: state=%0d want 0", state); end
   endtask

   task automatic test_waw();
      idle(); id_valid = 1; ex_ready = 1; rd_we = 1; rd_addr = 7;
      for (int k = 0; k < 3; k++) begin
         #1; tests++;
         if (issue_valid !== 1'b1) begin fails++; $display("FAIL waw_fill%0d: issue=%b want 1", k, issue_valid); end
         tick();
      end
      #1; tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL waw_overflow: stall=%b want 1", stall); end
      wb_valid = 1; wb_addr = 7;
      tick();
      wb_valid = 0;
      #1; tests++;
      if (issue_valid !== 1'b1) begin fails++; $display("FAIL waw_release: issue=%b want 1", issue_valid); end
      tick();
      #1; tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL waw_full_again: stall=%b want 1 (pend=3)", stall); end
      idle(); wb_valid = 1; wb_addr = 7;
      repeat (3) tick();
      idle();
   endtask

   task automatic test_same_cycle();
      idle(); id_valid = 1; ex_ready = 1; rd_we = 1; rd_addr = 9;
      tick();
      wb_valid = 1; wb_addr = 9;
      tick();
      idle(); id_valid = 1; ex_ready = 1; rs1_use = 1; rs1_addr = 9;
      #1; tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL same_cycle_hold: stall=%b want 1", stall); end
      id_valid = 0; wb_valid = 1; wb_addr = 9;
      tick();
      id_valid = 1; wb_valid = 0;
      #1; tests++;
      if (issue_valid !== 1'b1) begin fails++; $display("FAIL same_cycle_one_left: issue=%b want 1", issue_valid); end
      tick(); idle();
   endtask

   task automatic test_zero_reg();
      idle(); id_valid = 1; ex_ready = 1; rd_we = 1; rd_addr = 0; rs1_use = 1; rs1_addr = 0; rs2_use = 1; rs2_addr = 0;
      for (int k = 0; k < 4; k++) begin
         #1; tests++;
         if (issue_valid !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL zero_reg%0d: issue=%b stall=%b want 1 0", k, issue_valid, stall); end
         tick();
      end
      idle();
   endtask

   task automatic test_fence();
      int c0;
      idle(); id_valid = 1; ex_ready = 1; rd_we = 1; rd_addr = 3;
      tick();
      rd_we = 0; fence = 1; c0 = cnt_m;
      #1; tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL fence_stall: stall=%b want 1", stall); end
      tick(); tick(); tests++;
      if (state !== 2'd2 || int'(stall_cnt) !== cnt_m || cnt_m <= c0) begin
         fails++; $display("FAIL fence_drain: state=%0d cnt=%0d want 2 %0d", state, stall_cnt, cnt_m);
      end
      wb_valid = 1; wb_addr = 3;
      tick();
      wb_valid = 0;
      #1; tests++;
      if (issue_valid !== 1'b1) begin fails++; $display("FAIL fence_release: issue=%b want 1", issue_valid); end
      tick();
      fence = 0; rd_we = 1;
      tick();
      rd_we = 0; fence = 1;
      tick(); tests++;
      if (state !== 2'd2) begin fails++; $display("FAIL fence_redrain: state=%0d want 2", state); end
      flush = 1;
      #1; tests++;
      if (id_ready !== 1'b1 || stall !== 1'b0 || issue_valid !== 1'b0) begin
         fails++; $display("FAIL fence_flush: ready=%b stall=%b issue=%b want 1 0 0", id_ready, stall, issue_valid);
      end
      tick(); tests++;
      if (state !== 2'd0) begin fails++; $display("FAIL fence_flush_run: state=%0d want 0", state); end
      idle(); wb_valid = 1; wb_addr = 3;
      tick(); idle();
   endtask

   task automatic test_async_reset();
      rst = 0; model_reset(); #1;
      @(negedge clk); rst = 1;
      idle(); id_valid = 1;
      repeat (10) tick();
      tests++;
      if (stall_cnt !== 4'd10 || state !== 2'd1) begin fails++; $display("FAIL pre_reset: cnt=%0d state=%0d want 10 1", stall_cnt, state); end
      #2 rst = 0;
      #1; tests++;
      if (stall_cnt !== '0 || state !== 2'd0 || stall !== 1'b0) begin
         fails++; $display("FAIL async_reset: cnt=%0d state=%0d stall=%b want 0 0 0", stall_cnt, state, stall);
      end
      model_reset();
      @(negedge clk); rst = 1; ex_ready = 1;
      #1; tests++;
      if (issue_valid !== 1'b1) begin fails++; $display("FAIL post_reset_issue: issue=%b want 1", issue_valid); end
      tick(); idle();
   endtask

   task automatic test_saturate();
      idle(); id_valid = 1;
      repeat (2**CW + 3) tick();
      tests++;
      if (stall_cnt !== 4'hF || cnt_m != 15) begin fails++; $display("FAIL stall_cnt_sat: cnt=%0d want 15", stall_cnt); end
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 4) != 0);
         rs1_use  = $urandom_range(0, 1); rs1_addr = 5'($urandom_range(0, 7));
         rs2_use  = $urandom_range(0, 1); rs2_addr = 5'($urandom_range(0, 7));
         rd_we    = ($urandom_range(0, 3) != 0); rd_addr = 5'($urandom_range(0, 7));
         fence    = ($urandom_range(0, 15) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         wb_valid = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7));
         #1; predict(); tests++;
         if (issue_valid !== e_issue || id_ready !== (e_issue || flush) || stall !== e_stall
             || int'(state) !== st_m || int'(stall_cnt) !== cnt_m) begin
            fails++;
            $display("FAIL random%0d: iv/rdy/stall=%b%b%b state=%0d cnt=%0d want %b%b%b %0d %0d", n,
                     issue_valid, id_ready, stall, state, stall_cnt, e_issue, e_issue || flush, e_stall, st_m, cnt_m);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_raw();
      test_waw();
      test_same_cycle();
      test_zero_reg();
      test_fence();
      test_async_reset();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
